// File: rtl/param_pipe_counter_pkg.sv
// Purpose: shared constants for param_pipe_counter (count direction, default geometry).
// Latency: n/a (package only).
// Backpressure: n/a.
package param_pipe_counter_pkg;

    // Count direction as sampled on the dir port.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int DEF_WIDTH  = 7;
    localparam int DEF_STAGES = 2;
    localparam int DEF_MODULO = 100;

endpackage

// File: rtl/param_pipe_counter_pipe_stage.sv
// Purpose: one register slot of the count delay line, carrying a value and its valid flag.
// Latency: 1 cycle from d/vld_in to q/vld.
// Backpressure: none; captures every rising edge.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (clears q and vld)
//   d, vld_in  - value and valid flag from the previous slot (or the live count)
//   q, vld     - registered value and valid flag
module pipe_stage
    import param_pipe_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             vld_in,
    output logic [WIDTH-1:0] q,
    output logic             vld
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            vld <= 1'b0;
        end else begin
            q   <= d;
            vld <= vld_in;
        end
    end

endmodule

// File: rtl/param_pipe_counter.sv
// Purpose: modulo up/down counter with clear/load and a free-running delay line of the count.
// Latency: cnt and wrap update 1 cycle after the controlling inputs; cnt_pipe slice k lags cnt by k+1 cycles.
// Backpressure: none; every edge is acted on (priority clr > load > en).
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset (all outputs to 0 without a clock)
//   en, dir         - count enable and direction (0 up, 1 down)
//   load, load_val  - synchronous load; values >= MODULO saturate to MODULO-1
//   clr             - synchronous clear to 0
//   cnt             - live count, always < MODULO
//   cnt_pipe        - STAGES delayed copies of cnt, LSB slice newest
//   vld_pipe        - bit k set once slice k holds a post-reset value
//   wrap            - one-cycle pulse registered with a wrapping count step
module param_pipe_counter
    import param_pipe_counter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int MODULO = DEF_MODULO
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     dir,
    input  logic                     load,
    input  logic [WIDTH-1:0]         load_val,
    input  logic                     clr,
    output logic [WIDTH-1:0]         cnt,
    output logic [STAGES*WIDTH-1:0]  cnt_pipe,
    output logic [STAGES-1:0]        vld_pipe,
    output logic                     wrap
);

    // Compares are done one bit wider so MODULO = 2^WIDTH stays representable.
    localparam logic [WIDTH:0] MOD_MAX = (WIDTH+1)'(MODULO - 1);

    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;
    logic             at_top;
    logic             at_zero;
    logic             lv_over;

    assign at_top  = ({1'b0, cnt} >= MOD_MAX);
    assign at_zero = (cnt == '0);
    assign lv_over = ({1'b0, load_val} > MOD_MAX);

    always_comb begin
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        if (clr) begin
            cnt_nxt = '0;
        end else if (load) begin
            cnt_nxt = lv_over ? MOD_MAX[WIDTH-1:0] : load_val;
        end else if (en) begin
            if (dir_e'(dir) == DIR_DOWN) begin
                if (at_zero) begin
                    cnt_nxt  = MOD_MAX[WIDTH-1:0];
                    wrap_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - WIDTH'(1);
                end
            end else begin
                // cnt < MODULO-1 here, so the WIDTH-bit increment cannot overflow.
                if (at_top) begin
                    cnt_nxt  = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            wrap <= wrap_nxt;
        end
    end

    // Delay line: slot 0 samples the live count, slot k samples slot k-1.
    // The valid flags form a shift register of 1s filling from slot 0 after reset.
    logic [WIDTH-1:0] stage_q [STAGES];
    logic [STAGES-1:0] stage_v;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;

        if (k == 0) begin : g_head
            assign d_in = cnt;
            assign v_in = 1'b1;
        end else begin : g_body
            assign d_in = stage_q[k-1];
            assign v_in = stage_v[k-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .d      (d_in),
            .vld_in (v_in),
            .q      (stage_q[k]),
            .vld    (stage_v[k])
        );

        assign cnt_pipe[k*WIDTH +: WIDTH] = stage_q[k];
    end

    assign vld_pipe = stage_v;

endmodule

// File: tb/tb_param_pipe_counter.sv
// Purpose: randomized and directed checks of param_pipe_counter against a behavioural model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_param_pipe_counter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        dir;
    logic        load;
    logic [6:0]  load_val;
    logic        clr;

    // default instance: WIDTH=7, STAGES=2, MODULO=100
    logic [6:0]  cnt_a;
    logic [13:0] cp_a;
    logic [1:0]  vp_a;
    logic        wrap_a;

    // sweep instance: WIDTH=4, STAGES=4, MODULO=16
    logic [3:0]  cnt_b;
    logic [15:0] cp_b;
    logic [3:0]  vp_b;
    logic        wrap_b;

    int n_vec;
    int n_bad;

    // model state
    int m_cnt_a, m_cnt_b;
    int m_wrap_a, m_wrap_b;
    int m_hist_a[$];
    int m_hist_b[$];

    param_pipe_counter dut_a (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .clr      (clr),
        .cnt      (cnt_a),
        .cnt_pipe (cp_a),
        .vld_pipe (vp_a),
        .wrap     (wrap_a)
    );

    param_pipe_counter #(
        .WIDTH  (4),
        .STAGES (4),
        .MODULO (16)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .load_val (load_val[3:0]),
        .clr      (clr),
        .cnt      (cnt_b),
        .cnt_pipe (cp_b),
        .vld_pipe (vp_b),
        .wrap     (wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Next count from the counting rules, in plain modulo arithmetic.
    task automatic next_val(input int c, input int md, input int lv,
                            input bit c_clr, input bit c_load, input bit c_en, input bit c_dir,
                            output int n, output int w);
        n = c;
        w = 0;
        if (c_clr) begin
            n = 0;
        end else if (c_load) begin
            n = (lv >= md) ? md - 1 : lv;
        end else if (c_en) begin
            if (c_dir) begin
                n = (c + md - 1) % md;
                w = (c == 0);
            end else begin
                n = (c + 1) % md;
                w = (c + 1 == md);
            end
        end
    endtask

    task automatic model_reset();
        m_cnt_a  = 0;
        m_cnt_b  = 0;
        m_wrap_a = 0;
        m_wrap_b = 0;
        m_hist_a.delete();
        m_hist_b.delete();
    endtask

    task automatic model_edge();
        int n, w;
        m_hist_a.push_front(m_cnt_a);
        if (m_hist_a.size() > 2) void'(m_hist_a.pop_back());
        m_hist_b.push_front(m_cnt_b);
        if (m_hist_b.size() > 4) void'(m_hist_b.pop_back());
        next_val(m_cnt_a, 100, int'(load_val), clr, load, en, dir, n, w);
        m_cnt_a  = n;
        m_wrap_a = w;
        next_val(m_cnt_b, 16, int'(load_val[3:0]), clr, load, en, dir, n, w);
        m_cnt_b  = n;
        m_wrap_b = w;
    endtask

    task automatic compare_all();
        int ev;
        check("cnt_a", int'(cnt_a), m_cnt_a);
        check("wrap_a", int'(wrap_a), m_wrap_a);
        ev = 0;
        for (int k = 0; k < 2; k++) begin
            check("pipe_a", int'(cp_a[k*7 +: 7]), (k < m_hist_a.size()) ? m_hist_a[k] : 0);
            if (k < m_hist_a.size()) ev |= (1 << k);
        end
        check("vld_a", int'(vp_a), ev);
        check("cnt_b", int'(cnt_b), m_cnt_b);
        check("wrap_b", int'(wrap_b), m_wrap_b);
        ev = 0;
        for (int k = 0; k < 4; k++) begin
            check("pipe_b", int'(cp_b[k*4 +: 4]), (k < m_hist_b.size()) ? m_hist_b[k] : 0);
            if (k < m_hist_b.size()) ev |= (1 << k);
        end
        check("vld_b", int'(vp_b), ev);
    endtask

    // One rising edge: advance the model with the inputs in force, then compare 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_in(input bit i_en, input bit i_dir, input bit i_load,
                          input int i_lv, input bit i_clr);
        en       = i_en;
        dir      = i_dir;
        load     = i_load;
        load_val = 7'(i_lv);
        clr      = i_clr;
    endtask

    initial begin
        int pulses;
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        #2;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // free count up across the 99 -> 0 wrap
        set_in(1, 0, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 105; i++) begin
            tick();
            if (wrap_a) pulses++;
        end
        check("up_wrap_pulses", pulses, 1);
        check("up_cnt_after_105", int'(cnt_a), 5);

        // down wrap from 0
        set_in(0, 0, 0, 0, 1);
        tick();
        set_in(1, 1, 0, 0, 0);
        tick();
        check("down_wrap_cnt", int'(cnt_a), 99);
        check("down_wrap_pulse", int'(wrap_a), 1);
        set_in(0, 1, 0, 0, 0);
        tick();
        check("down_wrap_single", int'(wrap_a), 0);

        // load, saturating load, clear over load
        set_in(1, 0, 1, 42, 0);
        tick();
        check("load_42", int'(cnt_a), 42);
        set_in(1, 0, 1, 120, 0);
        tick();
        check("load_sat", int'(cnt_a), 99);
        check("load_no_wrap", int'(wrap_a), 0);
        set_in(1, 0, 1, 77, 1);
        tick();
        check("clr_over_load", int'(cnt_a), 0);

        // asynchronous reset mid-count at 57
        set_in(0, 0, 1, 57, 0);
        tick();
        set_in(1, 0, 0, 0, 0);
        check("pre_rst_cnt", int'(cnt_a), 57);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        #2;
        rst = 1'b0;
        check("vld_after_rst", int'(vp_a), 0);
        tick();
        check("vld_fill_1", int'(vp_a), 1);
        tick();
        check("vld_fill_2", int'(vp_a), 3);

        // sweep instance: run through the 15 -> 0 wrap (started at 2 here)
        for (int i = 0; i < 14; i++) tick();
        check("b_wrap_cnt", int'(cnt_b), 0);
        check("b_wrap_pulse", int'(wrap_b), 1);
        for (int i = 0; i < 4; i++) tick();
        check("b_slice3_lag", int'(cp_b[15:12]), 0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            set_in($urandom_range(1), $urandom_range(1),
                   ($urandom_range(15) == 0), $urandom_range(127),
                   ($urandom_range(31) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
